mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
Iterative RV32M multiply/divide unit, sitting in EX beside the combinational ALU.
- Decodes func3 when ALUOp selects the M-extension path (funct7 = 0000001).
- Executes one radix-2 step per cycle.
- Holds the pipeline via a valid/ready handshake until the result is consumed.
- Width is parametrised for the RV32 and RV64 data paths.

Parameters:
XLEN, 32, operand/result width in bits (power of 2, ≥8)
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  synchronous abort of the in-flight operation
valid_i  in  1  request valid
ready_o  out  1  unit idle, can accept a request
func3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a_i  in  XLEN  rs1 value
op_b_i  in  XLEN  rs2 value
valid_o  out  1  result valid
ready_i  in  1  consumer accepts result
result_o  out  XLEN  result
busy_o  out  1  state ≠ IDLE (pipeline stall request)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ready_o=1, valid_o=0, busy_o=0, result_o=0, all internal registers 0. Reset mid-operation discards the operation with no output.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - valid_i && ready_o accepts the request.
  - Operands, func3 and sign flags are latched.
  - Special cases go to DONE. All others go to CALC with counter=XLEN.
- Special cases (1-cycle fast path, valid_o on the cycle after accept):
  - op_b = 0, div/rem: DIV/DIVU → all-ones; REM/REMU → op_a.
  - DIV with op_a = signed min and op_b = −1: result signed min. REM with the same operands: result 0.
- Sign handling:
  - Signed operands are converted to magnitudes on accept. MULH: a, b signed. MULHSU: a signed, b unsigned. DIV/REM: both signed.
  - Result negate flag: mul = sa^sb; quotient = sa^sb; remainder = sa (sign of dividend).
- CALC:
  - Mul: shift-add into a 2·XLEN product register.
  - Div: restoring step on remainder/quotient.
  - One step per cycle. Counter decrements; at 1 → FIX.
- FIX: conditional two's-complement negate, then select output. MUL takes the low XLEN bits; MULH* takes the high XLEN bits; DIV* the quotient; REM* the remainder. → DONE.
- DONE: valid_o=1 and result_o held stable until ready_i. On valid_o && ready_i → IDLE; ready_o rises the next cycle.
- Latency, normal ops: accept edge T → valid_o high from T+XLEN+2.
- Outputs:
  - ready_o = (state==IDLE).
  - busy_o = !ready_o.
  - valid_o is never asserted outside DONE.
- flush_i (any state): next state IDLE, valid_o deasserts next cycle, result discarded. flush_i in IDLE with valid_i also set: request not accepted.
- Back-to-back: a new request is accepted only from IDLE. No overlap of accept with DONE.
- func3/operands are ignored while not IDLE. Arithmetic is modulo 2^XLEN; no exceptions raised.

Test Plan:
- XLEN=32, MUL a=7 b=6 → result_o=0x0000002A, valid_o exactly 34 cycles after accept, busy_o=1 throughout.
- MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE. MULH a=b=0xFFFFFFFF → 0x00000000. MULHSU a=0xFFFFFFFF b=2 → 0xFFFFFFFF.
- DIV a=−7 (0xFFFFFFF9) b=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0. Each with valid_o one cycle after accept.
- Hold result with ready_i=0 for 5 cycles: result_o stable, ready_o=0. ready_i=1 → ready_o=1 next cycle. New request accepted that cycle.
- flush_i at CALC cycle 10 → IDLE next cycle, no valid_o. rst_n pulse mid-CALC → all outputs at reset values immediately. XLEN=64 run of MUL/DIV → latency 66.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// One radix-2 step per cycle: shift-add for multiplies, restoring division
// for divides. Operands are reduced to magnitudes on accept and the result
// is conditionally negated in FIX. Divide-by-zero and signed overflow skip
// the iteration and present their architectural result on the next cycle.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t              r_state, w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [XLEN-1:0]     r_hi;      // product high half / partial remainder
    logic [XLEN-1:0]     r_lo;      // multiplier (shifted out) / dividend -> quotient
    logic [XLEN-1:0]     r_opd;     // multiplicand magnitude / divisor magnitude
    logic [2:0]          r_func3;
    logic                r_neg;     // negate the selected result in FIX
    logic [XLEN-1:0]     r_result;

    // ---------------- request decode ----------------
    logic            w_accept, w_is_div, w_is_rem;
    logic            w_a_signed, w_b_signed, w_sa, w_sb;
    logic [XLEN-1:0] w_mag_a, w_mag_b;
    logic            w_b_zero, w_ovf, w_special;
    logic [XLEN-1:0] w_special_res;

    assign w_accept   = valid_i && (r_state == S_IDLE) && !flush_i;
    assign w_is_div   = func3_i[2];
    assign w_is_rem   = func3_i[2] && func3_i[1];
    // MULH, MULHSU and signed DIV/REM treat rs1 as signed; MULH and DIV/REM also rs2.
    assign w_a_signed = (func3_i == 3'b001) || (func3_i == 3'b010) || (func3_i[2] && !func3_i[0]);
    assign w_b_signed = (func3_i == 3'b001) || (func3_i[2] && !func3_i[0]);
    assign w_sa       = w_a_signed && op_a_i[XLEN-1];
    assign w_sb       = w_b_signed && op_b_i[XLEN-1];
    assign w_mag_a    = w_sa ? -op_a_i : op_a_i;
    assign w_mag_b    = w_sb ? -op_b_i : op_b_i;

    assign w_b_zero   = (op_b_i == '0);
    assign w_ovf      = func3_i[2] && !func3_i[0]
                        && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b_i);
    assign w_special  = w_is_div && (w_b_zero || w_ovf);
    // Zero divisor: quotient all-ones, remainder = dividend.
    // Overflow: quotient = dividend (signed min), remainder 0.
    assign w_special_res = w_b_zero ? (func3_i[1] ? op_a_i : '1)
                                    : (func3_i[1] ? '0 : op_a_i);

    // ---------------- iteration step ----------------
    logic [XLEN:0]   w_add, w_sh, w_diff;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0] w_quo, w_rem, w_fix_res;

    assign w_add  = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_opd}) : {1'b0, r_hi};
    assign w_sh   = {r_hi, r_lo[XLEN-1]};
    assign w_diff = w_sh - {1'b0, r_opd};   // bit XLEN set means the trial subtract borrowed

    assign w_prod = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_quo  = r_neg ? -r_lo : r_lo;
    assign w_rem  = r_neg ? -r_hi : r_hi;

    // Result select in FIX: low product, high product, quotient or remainder.
    always_comb begin
        w_fix_res = w_prod[XLEN-1:0];
        case (r_func3)
            3'b000:                 w_fix_res = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_res = w_quo;
            default:                w_fix_res = w_rem;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        w_next = r_state;
        if (flush_i) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (valid_i) w_next = w_special ? S_DONE : S_CALC;
                S_CALC: if (r_cnt == CNT_W'(1)) w_next = S_FIX;
                S_FIX:  w_next = S_DONE;
                S_DONE: if (ready_i) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Datapath: latch on accept, iterate in CALC, produce the result in FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opd    <= '0;
            r_func3  <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_func3 <= func3_i;
            r_cnt   <= CNT_W'(XLEN);
            r_hi    <= '0;
            r_neg   <= w_is_rem ? w_sa : (w_sa ^ w_sb);
            if (w_is_div) begin
                r_lo  <= w_mag_a;
                r_opd <= w_mag_b;
            end else begin
                r_lo  <= w_mag_b;
                r_opd <= w_mag_a;
            end
            if (w_special) r_result <= w_special_res;
        end else if (r_state == S_CALC && !flush_i) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_func3[2]) begin
                if (w_diff[XLEN]) begin
                    r_hi <= w_sh[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], 1'b0};
                end else begin
                    r_hi <= w_diff[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], 1'b1};
                end
            end else begin
                r_hi <= w_add[XLEN:1];
                r_lo <= {w_add[0], r_lo[XLEN-1:1]};
            end
        end else if (r_state == S_FIX && !flush_i) begin
            r_result <= w_fix_res;
        end
    end

    assign ready_o  = (r_state == S_IDLE);
    assign busy_o   = !ready_o;
    assign valid_o  = (r_state == S_DONE);
    assign result_o = r_result;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: XLEN=32 and XLEN=64 instances.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        flush_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
    logic [2:0]  func3_i = '0;
    logic [31:0] op_a_i = '0, op_b_i = '0;
    logic        ready_o, valid_o, busy_o;
    logic [31:0] result_o;

    logic        f64 = 1'b0, v64 = 1'b0, r64 = 1'b0;
    logic [2:0]  fn64 = '0;
    logic [63:0] a64 = '0, b64 = '0;
    logic        rdy64, vo64, busy64;
    logic [63:0] res64;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(ready_o), .func3_i(func3_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .busy_o(busy_o)
    );

    mul_div_unit #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush_i(f64), .valid_i(v64),
        .ready_o(rdy64), .func3_i(fn64), .op_a_i(a64), .op_b_i(b64),
        .valid_o(vo64), .ready_i(r64), .result_o(res64), .busy_o(busy64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one request at a negedge, wait for valid_o, check latency/result, consume.
    task automatic run32(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         input bit consume);
        int cyc;
        logic busy_ok;
        chk({tag, "_ready"}, 64'(ready_o), 64'd1);
        valid_i = 1'b1; func3_i = f; op_a_i = a; op_b_i = b;
        @(negedge clk);
        valid_i = 1'b0; op_a_i = '1; op_b_i = '1; func3_i = 3'b000;
        cyc = 1; busy_ok = 1'b1;
        while (!valid_o && cyc < 200) begin
            busy_ok = busy_ok & busy_o;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'(lat));
        chk({tag, "_res"}, 64'(result_o), 64'(exp));
        if (lat > 1) chk({tag, "_busy"}, 64'(busy_ok & busy_o), 64'd1);
        if (consume) begin
            ready_i = 1'b1;
            @(negedge clk);
            ready_i = 1'b0;
        end
    endtask

    task automatic run64(input string tag, input logic [2:0] f, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp);
        int cyc;
        v64 = 1'b1; fn64 = f; a64 = a; b64 = b;
        @(negedge clk);
        v64 = 1'b0;
        cyc = 1;
        while (!vo64 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'd66);
        chk({tag, "_res"}, res64, exp);
        r64 = 1'b1;
        @(negedge clk);
        r64 = 1'b0;
    endtask

    initial begin
        int cyc;
        logic stable_ok, vseen;
        logic [31:0] held;

        // Reset state
        #1;
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_busy",  64'(busy_o),  64'd0);
        chk("rst_res",   64'(result_o), 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Multiplies
        run32("mul",    3'b000, 32'd7,        32'd6,        32'h0000002A, 34, 1);
        run32("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1);
        run32("mulh",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34, 1);
        run32("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, 1);

        // Divides
        run32("div",  3'b100, 32'hFFFFFFF9, 32'd2,   32'hFFFFFFFD, 34, 1);
        run32("rem",  3'b110, 32'hFFFFFFF9, 32'd2,   32'hFFFFFFFF, 34, 1);
        run32("divu", 3'b101, 32'd100,      32'd7,   32'd14,       34, 1);
        run32("remu", 3'b111, 32'd100,      32'd7,   32'd2,        34, 1);

        // Fast-path special cases
        run32("divu0", 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 1);
        run32("remu0", 3'b111, 32'd5,        32'd0,        32'd5,        1, 1);
        run32("divov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1);
        run32("remov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 1);

        // Hold result for 5 cycles with ready_i low
        run32("hold", 3'b000, 32'd1000, 32'd3000, 32'd3000000, 34, 0);
        held = result_o; stable_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            stable_ok = stable_ok & valid_o & !ready_o & (result_o == held);
        end
        chk("hold_stable", 64'(stable_ok), 64'd1);
        chk("hold_value",  64'(result_o), 64'd3000000);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        chk("release_ready", 64'(ready_o), 64'd1);
        chk("release_valid", 64'(valid_o), 64'd0);
        run32("b2b", 3'b101, 32'd100, 32'd7, 32'd14, 34, 1);

        // Flush at CALC cycle 10
        valid_i = 1'b1; func3_i = 3'b000; op_a_i = 32'd9; op_b_i = 32'd9;
        @(negedge clk);
        valid_i = 1'b0;
        for (int i = 0; i < 9; i++) @(negedge clk);
        chk("pre_flush_busy", 64'(busy_o), 64'd1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush_ready", 64'(ready_o), 64'd1);
        chk("flush_valid", 64'(valid_o), 64'd0);
        vseen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            vseen = vseen | valid_o | busy_o;
        end
        chk("flush_quiet", 64'(vseen), 64'd0);

        // flush_i with valid_i in IDLE: not accepted
        flush_i = 1'b1; valid_i = 1'b1; func3_i = 3'b000; op_a_i = 32'd2; op_b_i = 32'd2;
        @(negedge clk);
        flush_i = 1'b0; valid_i = 1'b0;
        chk("flush_idle_ready", 64'(ready_o), 64'd1);
        chk("flush_idle_busy",  64'(busy_o),  64'd0);

        // Reset mid-CALC
        valid_i = 1'b1; func3_i = 3'b101; op_a_i = 32'd50; op_b_i = 32'd5;
        @(negedge clk);
        valid_i = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(ready_o), 64'd1);
        chk("mid_rst_busy",  64'(busy_o),  64'd0);
        chk("mid_rst_valid", 64'(valid_o), 64'd0);
        chk("mid_rst_res",   64'(result_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        vseen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            vseen = vseen | valid_o;
        end
        chk("post_rst_quiet", 64'(vseen), 64'd0);

        // XLEN=64
        run64("mul64", 3'b000, 64'h0000_0001_0000_0000, 64'd3, 64'h0000_0003_0000_0000);
        run64("div64", 3'b100, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2);

        cyc = n_checks;
        $display("%0d/%0d checks passed", n_pass, cyc);
        $finish;
    end

endmodule
